// File: rtl/instr_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// instr_buffer_ctrl
// Circular instruction buffer between fetch/decode and dispatch. Up to four
// bundles are written per cycle at the tail and up to two are presented and
// popped per cycle at the head. A registered free-slot grant (num_fetch_o)
// throttles fetch, and a taken jump (flush_i) discards every buffered entry.
//
// Ports
//   clk_i         clock, all state updates on the rising edge
//   rst_n_i       synchronous active-low reset
//   flush_i       taken jump, empties the buffer
//   if_valid_i    fetch bundle valid this cycle
//   enq_count_i   number of valid bundle slots (0..4, slot 0 oldest)
//   enq_data_i    bundle payloads, slots 0..3
//   num_fetch_o   registered grant to fetch, min(free, 4)
//   deq_ready_i   entries consumed by dispatch this cycle (0..2)
//   deq_valid_o   bit i set when the entry at head+i is presented
//   deq_data_o    payloads at head+0 and head+1
//   count_o       current occupancy
//   empty_o       occupancy is zero
//   full_o        occupancy equals DEPTH
//   ovf_err_o     sticky, fetch wrote more slots than it was granted
// -----------------------------------------------------------------------------
module instr_buffer_ctrl #(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     flush_i,
   input  logic                     if_valid_i,
   input  logic [2:0]               enq_count_i,
   input  logic [ENTRY_W-1:0]       enq_data_i [0:3],
   output logic [2:0]               num_fetch_o,
   input  logic [1:0]               deq_ready_i,
   output logic [1:0]               deq_valid_o,
   output logic [ENTRY_W-1:0]       deq_data_o [0:1],
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic                     ovf_err_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [ENTRY_W-1:0] mem_q [0:DEPTH-1];
   logic [AW-1:0]      head_q, head_d;
   logic [AW-1:0]      tail_q, tail_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2:0]         num_fetch_q, num_fetch_d;
   logic               empty_q, empty_d;
   logic               full_q, full_d;
   logic               ovf_q, ovf_d;

   logic [2:0]         enq_req_s;
   logic [2:0]         enq_acc_s;
   logic               ovf_set_s;
   logic [1:0]         deq_req_s;
   logic [1:0]         n_valid_s;
   logic [1:0]         deq_acc_s;
   logic [CW-1:0]      free_s;

   // Next-state computation for pointers, occupancy, grant and error flag.
   always_comb begin
      // Out-of-range requests are clamped to the architectural maximum.
      enq_req_s = (enq_count_i > 3'd4) ? 3'd4 : enq_count_i;
      deq_req_s = (deq_ready_i == 2'd3) ? 2'd2 : deq_ready_i;

      enq_acc_s = 3'd0;
      ovf_set_s = 1'b0;
      if (if_valid_i && !flush_i) begin
         enq_acc_s = (enq_req_s > num_fetch_q) ? num_fetch_q : enq_req_s;
         ovf_set_s = (enq_req_s > num_fetch_q);
      end else begin
         enq_acc_s = 3'd0;
         ovf_set_s = 1'b0;
      end

      // Number of entries presented to dispatch this cycle.
      if (flush_i) begin
         n_valid_s = 2'd0;
      end else if (count_q >= CW'(2)) begin
         n_valid_s = 2'd2;
      end else begin
         n_valid_s = count_q[1:0];
      end

      deq_acc_s = (deq_req_s < n_valid_s) ? deq_req_s : n_valid_s;

      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + AW'(deq_acc_s);
         tail_d  = tail_q + AW'(enq_acc_s);
         count_d = count_q + CW'(enq_acc_s) - CW'(deq_acc_s);
      end

      free_s      = CW'(DEPTH) - count_d;
      num_fetch_d = (free_s > CW'(4)) ? 3'd4 : free_s[2:0];
      empty_d     = (count_d == '0);
      full_d      = (count_d == CW'(DEPTH));
      ovf_d       = ovf_q | ovf_set_s;
   end

   // Control state register with synchronous reset (reset beats flush).
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         num_fetch_q <= 3'd4;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         num_fetch_q <= num_fetch_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
         ovf_q       <= ovf_d;
      end
   end

   // Payload storage; contents are don't-care after reset or flush, so no reset.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < 4; k++) begin
         if (3'(k) < enq_acc_s) begin
            mem_q[tail_q + AW'(k)] <= enq_data_i[k];
         end
      end
   end

   // Presentation is combinational so a flush masks it in the same cycle.
   assign deq_valid_o   = {(n_valid_s == 2'd2), (n_valid_s != 2'd0)};
   assign deq_data_o[0] = mem_q[head_q];
   assign deq_data_o[1] = mem_q[head_q + AW'(1)];

   assign num_fetch_o = num_fetch_q;
   assign count_o     = count_q;
   assign empty_o     = empty_q;
   assign full_o      = full_q;
   assign ovf_err_o   = ovf_q;

endmodule
